// File: rtl/stream_fifo_pkg.sv
// Shared types and defaults for the stream FIFO read-side packet extractor.
package stream_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2,
      DROP = 2'd3
   } state_t;

   localparam int DEF_MAXLEN   = 32;
   localparam int DEF_CNTWIDTH = 16;

endpackage

// File: rtl/stream_sat_counter.sv
// Increment-by-one counter that sticks at all-ones instead of wrapping.
module stream_sat_counter
   import stream_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_CNTWIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/stream_fifo_pkt_reader.sv
// Pops length-prefixed packets from an FWFT FIFO and emits them as a sop/eop stream.
// Store-and-forward mode (WAIT state) is enabled by STREAM_FIFO_PKT_READER_STORE_FWD_EN.
module stream_fifo_pkt_reader
   import stream_fifo_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 6,
   parameter int LENWIDTH  = 8,
   parameter int MAXLEN    = DEF_MAXLEN,
   parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
   input  logic                 r_clk,
   input  logic                 r_rst_n,
   output logic                 f_en,
   input  logic                 f_valid,
   input  logic [DATAWIDTH-1:0] f_data,
   input  logic [ADDRWIDTH:0]   f_counter,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [DATAWIDTH-1:0] o_data,
   output logic                 o_sop,
   output logic                 o_eop,
   output logic [LENWIDTH-1:0]  o_len,
   output logic                 err,
   output logic [CNTWIDTH-1:0]  err_cnt,
   output logic [CNTWIDTH-1:0]  pkt_cnt
);

   localparam logic [31:0] MAXLEN_W = 32'(MAXLEN);
   localparam logic [LENWIDTH-1:0] ONE = LENWIDTH'(1);

   state_t              state_reg, state_next;
   logic [LENWIDTH-1:0] rem_reg, rem_next;
   logic [LENWIDTH-1:0] len_reg, len_next;
   logic                err_reg, err_next;
   logic                pkt_inc;
   logic [LENWIDTH-1:0] hdr_len;

   assign hdr_len = f_data[LENWIDTH-1:0];

`ifdef STREAM_FIFO_PKT_READER_STORE_FWD_EN
   localparam int CMPW = ((ADDRWIDTH + 1) > LENWIDTH) ? (ADDRWIDTH + 1) : LENWIDTH;
   logic resident;
   // Whole packet is in the FIFO once the fill level reaches the header length.
   assign resident = (CMPW'(f_counter) >= CMPW'(len_reg));
`else
   logic unused_counter;
   assign unused_counter = ^f_counter;
`endif

   always_comb begin
      state_next = state_reg;
      rem_next   = rem_reg;
      len_next   = len_reg;
      err_next   = 1'b0;
      pkt_inc    = 1'b0;
      f_en       = 1'b0;
      o_valid    = 1'b0;
      o_sop      = 1'b0;
      o_eop      = 1'b0;
      case (state_reg)
         IDLE: begin
            f_en = 1'b1;
            if (f_valid) begin
               len_next = hdr_len;
               rem_next = hdr_len;
               if (hdr_len == '0) begin
                  err_next = 1'b1;
               end else if (32'(hdr_len) > MAXLEN_W) begin
                  err_next   = 1'b1;
                  state_next = DROP;
               end else begin
`ifdef STREAM_FIFO_PKT_READER_STORE_FWD_EN
                  state_next = WAIT;
`else
                  state_next = XFER;
`endif
               end
            end
         end
         WAIT: begin
`ifdef STREAM_FIFO_PKT_READER_STORE_FWD_EN
            if (resident) begin
               state_next = XFER;
            end
`else
            state_next = IDLE;
`endif
         end
         XFER: begin
            o_valid = f_valid;
            f_en    = o_ready;
            o_sop   = f_valid && (rem_reg == len_reg);
            o_eop   = f_valid && (rem_reg == ONE);
            if (f_valid && o_ready) begin
               rem_next = rem_reg - ONE;
               if (rem_reg == ONE) begin
                  pkt_inc    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         DROP: begin
            f_en = 1'b1;
            if (f_valid) begin
               rem_next = rem_reg - ONE;
               if (rem_reg == ONE) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         state_reg <= IDLE;
         rem_reg   <= '0;
         len_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         rem_reg   <= rem_next;
         len_reg   <= len_next;
         err_reg   <= err_next;
      end
   end

   assign o_data = f_data;
   assign o_len  = len_reg;
   assign err    = err_reg;

   stream_sat_counter #(.WIDTH(CNTWIDTH)) u_err_cnt (
      .clk   (r_clk),
      .rst_n (r_rst_n),
      .inc   (err_next),
      .count (err_cnt)
   );

   stream_sat_counter #(.WIDTH(CNTWIDTH)) u_pkt_cnt (
      .clk   (r_clk),
      .rst_n (r_rst_n),
      .inc   (pkt_inc),
      .count (pkt_cnt)
   );

endmodule

// File: tb/tb_stream_fifo_pkt_reader.sv
// Bench for stream_fifo_pkt_reader: FWFT FIFO model feeding directed and random packets.
module tb_stream_fifo_pkt_reader;

   localparam int DW = 8;
   localparam int AW = 6;
   localparam int LW = 8;
   localparam int ML = 32;
   localparam int CW = 16;

   logic          r_clk = 1'b0;
   logic          r_rst_n;
   logic          f_en;
   logic          f_valid;
   logic [DW-1:0] f_data;
   logic [AW:0]   f_counter;
   logic          o_valid;
   logic          o_ready;
   logic [DW-1:0] o_data;
   logic          o_sop;
   logic          o_eop;
   logic [LW-1:0] o_len;
   logic          err;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] pkt_cnt;

   always #5 r_clk = ~r_clk;

   stream_fifo_pkt_reader #(
      .DATAWIDTH(DW), .ADDRWIDTH(AW), .LENWIDTH(LW), .MAXLEN(ML), .CNTWIDTH(CW)
   ) dut (
      .r_clk(r_clk), .r_rst_n(r_rst_n), .f_en(f_en), .f_valid(f_valid),
      .f_data(f_data), .f_counter(f_counter), .o_valid(o_valid), .o_ready(o_ready),
      .o_data(o_data), .o_sop(o_sop), .o_eop(o_eop), .o_len(o_len), .err(err),
      .err_cnt(err_cnt), .pkt_cnt(pkt_cnt)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic [7:0] len;
   } beat_t;

   logic [7:0] src_q[$];
   logic [7:0] fifo_q[$];
   beat_t      exp_q[$];

   int checks = 0;
   int failures = 0;
   int exp_err = 0;
   int exp_pkt = 0;
   int obs_err = 0;
   int xfer_cnt = 0;
   int ready_mode = 0;
   int pat_idx = 0;
   int arrive_pct = 100;
   int cnt_cap = -1;
   logic expect_quiet = 1'b0;
   logic stall_prev = 1'b0;
   logic in_pkt = 1'b0;
   logic [7:0] data_prev = 8'h00;
   logic [5:0] ready_pat = 6'b101001;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // base < 0 gives random payload; otherwise payload is base, base+1, ...
   task automatic push_pkt(input int len, input int base);
      logic [7:0] d;
      beat_t b;
      src_q.push_back(8'(len));
      if (len == 0) begin
         exp_err++;
      end else if (len > ML) begin
         exp_err++;
         for (int i = 0; i < len; i++) src_q.push_back(8'($urandom));
      end else begin
         exp_pkt++;
         for (int i = 0; i < len; i++) begin
            d = (base < 0) ? 8'($urandom) : 8'(base + i);
            src_q.push_back(d);
            b.data = d;
            b.sop  = (i == 0);
            b.eop  = (i == len - 1);
            b.len  = 8'(len);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic cycle();
      logic pop;
      beat_t e;
      int sz;
      if (src_q.size() > 0 && $urandom_range(99) < arrive_pct)
         fifo_q.push_back(src_q.pop_front());
      sz = fifo_q.size();
      f_valid = (sz > 0);
      f_data  = (sz > 0) ? fifo_q[0] : 8'h00;
      f_counter = 7'((cnt_cap >= 0 && sz > cnt_cap) ? cnt_cap : sz);
      case (ready_mode)
         0: o_ready = 1'b1;
         1: begin o_ready = ready_pat[pat_idx]; pat_idx = (pat_idx + 1) % 6; end
         default: o_ready = 1'($urandom_range(1));
      endcase
      #1;
      if (err === 1'b1) obs_err++;
      if (expect_quiet) chk("sf_quiet", o_valid, 0);
      if (stall_prev) begin
         chk("hold_valid", o_valid, 1);
         chk("hold_data", o_data, data_prev);
      end
`ifdef STREAM_FIFO_PKT_READER_STORE_FWD_EN
      if (in_pkt) chk("contiguous", o_valid, 1);
`endif
      if (o_valid && !o_ready) chk("bp_f_en", f_en, 0);
      if (o_valid && o_ready) begin
         xfer_cnt++;
         chk("xfer_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data", o_data, e.data);
            chk("sop", o_sop, e.sop);
            chk("eop", o_eop, e.eop);
            chk("len", o_len, e.len);
         end
         in_pkt = !o_eop;
      end
      stall_prev = o_valid && !o_ready;
      data_prev  = o_data;
      pop = f_en && f_valid;
      @(posedge r_clk);
      if (pop) void'(fifo_q.pop_front());
      @(negedge r_clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((src_q.size() > 0 || fifo_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
         cycle();
         n++;
      end
      chk("drain_in_time", 32'(n < 3000), 1);
      repeat (3) cycle();
      chk("err_cnt", err_cnt, exp_err);
      chk("pkt_cnt", pkt_cnt, exp_pkt);
      chk("err_pulses", obs_err, exp_err);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_f_en"}, f_en, 1);
      chk({tag, "_o_valid"}, o_valid, 0);
      chk({tag, "_o_sop"}, o_sop, 0);
      chk({tag, "_o_eop"}, o_eop, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_o_len"}, o_len, 0);
      chk({tag, "_err_cnt"}, err_cnt, 0);
      chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
   endtask

   initial begin
      r_rst_n   = 1'b0;
      f_valid   = 1'b0;
      f_data    = 8'h00;
      f_counter = '0;
      o_ready   = 1'b0;
      @(negedge r_clk);
      @(negedge r_clk);
      check_reset_outputs("reset");
      r_rst_n = 1'b1;

      // Basic 3-word packet, always ready.
      push_pkt(3, 'hA1);
      drain();
      chk("o_len_after", o_len, 3);

      // Same packet under a fixed backpressure pattern.
      ready_mode = 1;
      push_pkt(3, 'hA1);
      drain();

      // Zero-length header followed by a good packet.
      ready_mode = 0;
      push_pkt(0, -1);
      push_pkt(2, 'hB1);
      drain();

      // Oversized header: its 40 words are discarded, then a 1-word packet.
      push_pkt(40, -1);
      push_pkt(1, 'hC1);
      drain();

`ifdef STREAM_FIFO_PKT_READER_STORE_FWD_EN
      // Fill level held below the length keeps the packet back.
      cnt_cap = 2;
      push_pkt(4, -1);
      repeat (6) cycle();
      expect_quiet = 1'b1;
      repeat (8) cycle();
      expect_quiet = 1'b0;
      cnt_cap = -1;
      drain();
`endif

      // Random lengths (including illegal ones), random arrival and backpressure.
      arrive_pct = 60;
      ready_mode = 2;
      for (int p = 0; p < 25; p++) push_pkt($urandom_range(40), -1);
      drain();

      // Reset in the middle of a 5-word packet.
      arrive_pct = 100;
      ready_mode = 0;
      xfer_cnt = 0;
      push_pkt(5, 'hE1);
      for (int n = 0; n < 50 && xfer_cnt < 2; n++) cycle();
      chk("mid_pkt_progress", xfer_cnt, 2);
      r_rst_n = 1'b0;
      src_q.delete();
      fifo_q.delete();
      exp_q.delete();
      exp_err = 0;
      exp_pkt = 0;
      obs_err = 0;
      stall_prev = 1'b0;
      in_pkt = 1'b0;
      f_valid = 1'b0;
      f_data = 8'h00;
      f_counter = '0;
      #1;
      check_reset_outputs("midrst");
      @(negedge r_clk);
      r_rst_n = 1'b1;
      push_pkt(2, 'hD1);
      drain();
      chk("o_len_post_reset", o_len, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
